// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: hold codes,
// controller states and reset polarity.
package pipe_ctrl_pkg;

  localparam logic ResetEnable = 1'b0;

  typedef enum logic [2:0] {
    Hold_None = 3'b000,
    Hold_PC   = 3'b001,
    Hold_IF   = 3'b010,
    Hold_ID   = 3'b011
  } hold_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DATA  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic hold_e hold_max(
    input hold_e a,
    input hold_e b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pc_ctrl_cnt.sv
// Loadable up/down counter shared by the flush
// and data-timeout sequencing.
module pc_ctrl_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_Clk,
  input  logic         i_reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  always_ff @(posedge i_Clk or negedge i_reset) begin
    if (i_reset == ResetEnable) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Bus arbiter between fetch and data accesses, jump
// flush sequencer and pipeline hold code generator.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        i_Clk,
  input  logic        i_reset,
  input  logic        i_data_req,
  input  logic        i_bus_ack,
  input  logic        i_jump_flag,
  input  logic [31:0] i_jump_addr,
  input  logic        i_hold_req,
  output logic        o_grant_inst,
  output logic        o_grant_data,
  output logic [2:0]  o_hold_flag,
  output logic        o_jump_flag,
  output logic [31:0] o_jump_addr,
  output logic        o_bus_err
);

  localparam logic [7:0] FlushLoad = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] ToLast    = 8'(TIMEOUT_CYCLES - 1);

  state_e      state, state_n;
  logic        pend;
  logic [31:0] pend_addr;
  logic        pend_any;
  logic [31:0] pend_tgt;
  logic        enter_flush;
  logic        err_n;
  logic        cnt_ld;
  logic [7:0]  cnt_ld_val;
  logic        cnt_inc;
  logic        cnt_dec;
  logic [7:0]  cnt;
  hold_e       hold;

  // A jump seen this cycle counts as pending already.
  assign pend_any = pend | i_jump_flag;
  assign pend_tgt = i_jump_flag ? i_jump_addr : pend_addr;

  pc_ctrl_cnt #(.W(8)) u_cnt (
    .i_Clk    (i_Clk),
    .i_reset  (i_reset),
    .load     (cnt_ld),
    .load_val (cnt_ld_val),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .cnt      (cnt)
  );

  always_ff @(posedge i_Clk or negedge i_reset) begin
    if (i_reset == ResetEnable) begin
      state <= FETCH;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    enter_flush = 1'b0;
    err_n       = 1'b0;
    cnt_ld      = 1'b0;
    cnt_ld_val  = 8'd0;
    cnt_inc     = 1'b0;
    cnt_dec     = 1'b0;
    unique case (state)
      FETCH: begin
        if (i_data_req) begin
          state_n = DATA;
          cnt_ld  = 1'b1;
        end else if (pend_any) begin
          state_n     = FLUSH;
          enter_flush = 1'b1;
        end
      end
      DATA: begin
        if (i_bus_ack || cnt == ToLast) begin
          err_n = ~i_bus_ack;
          if (pend_any) begin
            state_n     = FLUSH;
            enter_flush = 1'b1;
          end else begin
            state_n = FETCH;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      FLUSH: begin
        if (i_jump_flag) begin
          enter_flush = 1'b1;
        end else if (cnt == 8'd0) begin
          state_n = FETCH;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_n = FETCH;
    endcase
    if (enter_flush) begin
      cnt_ld     = 1'b1;
      cnt_ld_val = FlushLoad;
    end
  end

  always_comb begin
    o_grant_inst = 1'b0;
    o_grant_data = 1'b0;
    hold         = Hold_None;
    unique case (state)
      FETCH: begin
        if (i_data_req) begin
          o_grant_data = 1'b1;
          hold         = Hold_IF;
        end else begin
          o_grant_inst = 1'b1;
        end
      end
      DATA: begin
        o_grant_data = 1'b1;
        hold         = Hold_IF;
      end
      FLUSH: begin
        o_grant_inst = 1'b1;
        hold         = Hold_IF;
      end
      default: o_grant_inst = 1'b1;
    endcase
    if (i_hold_req) begin
      hold = hold_max(hold, Hold_ID);
    end
    o_hold_flag = hold;
  end

  always_ff @(posedge i_Clk or negedge i_reset) begin
    if (i_reset == ResetEnable) begin
      pend        <= 1'b0;
      pend_addr   <= '0;
      o_jump_flag <= 1'b0;
      o_jump_addr <= '0;
      o_bus_err   <= 1'b0;
    end else begin
      o_jump_flag <= enter_flush;
      o_bus_err   <= err_n;
      if (enter_flush) begin
        pend        <= 1'b0;
        o_jump_addr <= pend_tgt;
      end else if (i_jump_flag) begin
        pend      <= 1'b1;
        pend_addr <= i_jump_addr;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random
// traffic against a cycle-level reference model.
module tb_pipe_ctrl;

  localparam int FC = 2;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_data_req = 1'b0;
  logic        i_bus_ack = 1'b0;
  logic        i_jump_flag = 1'b0;
  logic [31:0] i_jump_addr = '0;
  logic        i_hold_req = 1'b0;
  logic        o_grant_inst;
  logic        o_grant_data;
  logic [2:0]  o_hold_flag;
  logic        o_jump_flag;
  logic [31:0] o_jump_addr;
  logic        o_bus_err;

  int vectors = 0;
  int errs = 0;

  int          m_flush_left;
  int          m_data_cyc;
  bit          m_in_data;
  bit          m_pend;
  logic [31:0] m_paddr;
  logic [31:0] m_ja;
  bit          m_jf;
  bit          m_err;

  pipe_ctrl #(
    .FLUSH_CYCLES   (FC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_Clk        (clk),
    .i_reset      (i_reset),
    .i_data_req   (i_data_req),
    .i_bus_ack    (i_bus_ack),
    .i_jump_flag  (i_jump_flag),
    .i_jump_addr  (i_jump_addr),
    .i_hold_req   (i_hold_req),
    .o_grant_inst (o_grant_inst),
    .o_grant_data (o_grant_data),
    .o_hold_flag  (o_hold_flag),
    .o_jump_flag  (o_jump_flag),
    .o_jump_addr  (o_jump_addr),
    .o_bus_err    (o_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0;
    m_data_cyc   = 0;
    m_in_data    = 0;
    m_pend       = 0;
    m_paddr      = '0;
    m_ja         = '0;
    m_jf         = 0;
    m_err        = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_data_req  = 0;
    i_bus_ack   = 0;
    i_jump_flag = 0;
    i_hold_req  = 0;
    i_reset     = 0;
    #1;
    model_reset();
    chk("rst_gi", 32'(o_grant_inst), 32'd1);
    chk("rst_gd", 32'(o_grant_data), 32'd0);
    chk("rst_hold", 32'(o_hold_flag), 32'd0);
    chk("rst_jf", 32'(o_jump_flag), 32'd0);
    chk("rst_ja", o_jump_addr, 32'd0);
    chk("rst_err", 32'(o_bus_err), 32'd0);
    @(negedge clk);
    i_reset = 1;
  endtask

  // One clock of stimulus: check this cycle, then advance model.
  task automatic step(
    input logic        req,
    input logic        ack,
    input logic        jf,
    input logic [31:0] ja,
    input logic        hr
  );
    bit          egi, egd, pa, take;
    int          eh;
    logic [31:0] pt;
    @(negedge clk);
    i_data_req  = req;
    i_bus_ack   = ack;
    i_jump_flag = jf;
    i_jump_addr = ja;
    i_hold_req  = hr;
    #1;
    if (m_flush_left > 0) begin
      egi = 1; egd = 0; eh = 2;
    end else if (m_in_data || req) begin
      egi = 0; egd = 1; eh = 2;
    end else begin
      egi = 1; egd = 0; eh = 0;
    end
    if (hr) eh = 3;
    chk("grant_inst", 32'(o_grant_inst), 32'(egi));
    chk("grant_data", 32'(o_grant_data), 32'(egd));
    chk("hold", 32'(o_hold_flag), 32'(eh));
    chk("jump_flag", 32'(o_jump_flag), 32'(m_jf));
    chk("jump_addr", o_jump_addr, m_ja);
    chk("bus_err", 32'(o_bus_err), 32'(m_err));
    pa    = m_pend || jf;
    pt    = jf ? ja : m_paddr;
    m_jf  = 0;
    m_err = 0;
    take  = 0;
    if (m_flush_left > 0) begin
      if (jf) take = 1;
      else m_flush_left--;
    end else if (m_in_data) begin
      if (ack || m_data_cyc + 1 == TO) begin
        m_in_data = 0;
        m_err     = !ack;
        take      = pa;
      end else begin
        m_data_cyc++;
      end
    end else if (req) begin
      m_in_data  = 1;
      m_data_cyc = 0;
    end else begin
      take = pa;
    end
    if (take) begin
      m_flush_left = FC;
      m_jf         = 1;
      m_ja         = pt;
      m_pend       = 0;
    end else if (jf) begin
      m_pend  = 1;
      m_paddr = ja;
    end
  endtask

  initial begin
    bit          req_on;
    bit          last_jf;
    bit          was_data;
    logic        r, a, j, h;
    logic [31:0] addr;
    model_reset();
    do_reset();
    // data access, ack three cycles after the grant
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // plain jump
    step(0, 0, 1, 32'h40, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    // jump alongside a data request waits for the data
    step(1, 0, 1, 32'h80, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    // timeout with no ack
    repeat (TO + 1) step(1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    // load-use hold overlapping a data access
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // reset in the middle of an access, then a clean one
    step(1, 0, 1, 32'hC0, 0);
    step(1, 0, 0, 0, 0);
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);

    req_on  = 0;
    last_jf = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        req_on  = 0;
        last_jf = 0;
      end
      if (!req_on && $urandom_range(0, 5) == 0) req_on = 1;
      r = req_on;
      a = m_in_data && ($urandom_range(0, 2) == 0);
      j = !last_jf && ($urandom_range(0, 7) == 0);
      h = ($urandom_range(0, 3) == 0);
      addr = $urandom & 32'hFFFF_FFFC;
      was_data = m_in_data;
      step(r, a, j, addr, h);
      last_jf = j;
      if (was_data && !m_in_data) req_on = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
